// File: rtl/cfg_reg_arbiter.sv
// ============================================================================
// cfg_reg_arbiter: configuration register bank shared by two requesters
// through a round-robin arbiter, with registered reads. Rev 1.0
// ============================================================================
`default_nettype none

module cfg_reg_arbiter #(
  parameter int NUM_CFG    = 16,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         a_valid,
  input  logic                         a_we,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [REG_WIDTH-1:0]         a_wdata,
  output logic                         a_ready,
  output logic                         a_rvalid,
  output logic [REG_WIDTH-1:0]         a_rdata,
  input  logic                         b_valid,
  input  logic                         b_we,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [REG_WIDTH-1:0]         b_wdata,
  output logic                         b_ready,
  output logic                         b_rvalid,
  output logic [REG_WIDTH-1:0]         b_rdata,
  output logic                         addr_err,
  output logic [NUM_CFG*REG_WIDTH-1:0] config_regs
);

  localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_CFG_W = NUM_CFG[ADDR_WIDTH:0];

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} resp_state_t;

  logic [REG_WIDTH-1:0]  regs [NUM_CFG];
  logic                  prio;
  resp_state_t           a_state, a_state_next;
  resp_state_t           b_state, b_state_next;

  logic                  grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_wdata;
  logic [IDX_W-1:0]      sel_idx;
  logic                  in_range;
  logic [REG_WIDTH-1:0]  rd_value;

  // A lone requester always wins; under contention prio picks the port.
  assign a_ready = !rst && ena && a_valid && (!b_valid || !prio);
  assign b_ready = !rst && ena && b_valid && (!a_valid ||  prio);
  assign grant   = a_ready || b_ready;

  assign sel_we    = a_ready ? a_we    : b_we;
  assign sel_addr  = a_ready ? a_addr  : b_addr;
  assign sel_wdata = a_ready ? a_wdata : b_wdata;
  assign sel_idx   = sel_addr[IDX_W-1:0];
  assign in_range  = ({1'b0, sel_addr} < NUM_CFG_W);
  assign rd_value  = in_range ? regs[sel_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CFG; k++) regs[k] <= '0;
      prio     <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= grant && !in_range;
      if (grant) begin
        // Pointer moves to the port that just lost (or was idle).
        prio <= a_ready;
        if (sel_we && in_range) regs[sel_idx] <= sel_wdata;
      end
      if (a_ready && !a_we) a_rdata <= rd_value;
      if (b_ready && !b_we) b_rdata <= rd_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state <= IDLE;
      b_state <= IDLE;
    end else begin
      a_state <= a_state_next;
      b_state <= b_state_next;
    end
  end

  always_comb begin
    a_state_next = IDLE;
    b_state_next = IDLE;
    if (a_ready && !a_we) a_state_next = RESP;
    if (b_ready && !b_we) b_state_next = RESP;
  end

  assign a_rvalid = (a_state == RESP);
  assign b_rvalid = (b_state == RESP);

  generate
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_flat
      assign config_regs[k*REG_WIDTH +: REG_WIDTH] = regs[k];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cfg_reg_arbiter.sv
// ============================================================================
// tb_cfg_reg_arbiter: directed and random checks against a reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cfg_reg_arbiter;

  localparam int NUM_CFG    = 16;
  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 5;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         ena;
  logic                         a_valid, a_we, a_ready, a_rvalid;
  logic [ADDR_WIDTH-1:0]        a_addr;
  logic [REG_WIDTH-1:0]         a_wdata, a_rdata;
  logic                         b_valid, b_we, b_ready, b_rvalid;
  logic [ADDR_WIDTH-1:0]        b_addr;
  logic [REG_WIDTH-1:0]         b_wdata, b_rdata;
  logic                         addr_err;
  logic [NUM_CFG*REG_WIDTH-1:0] config_regs;

  cfg_reg_arbiter #(
    .NUM_CFG(NUM_CFG), .REG_WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .addr_err(addr_err), .config_regs(config_regs)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference state
  logic [REG_WIDTH-1:0] m_regs [NUM_CFG];
  bit                   m_prio;
  logic                 m_arv, m_brv, m_err;
  logic [REG_WIDTH-1:0] m_ard, m_brd;
  bit                   last_a_acc, last_b_acc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CFG*REG_WIDTH-1:0] model_flat();
    logic [NUM_CFG*REG_WIDTH-1:0] f;
    for (int k = 0; k < NUM_CFG; k++) f[k*REG_WIDTH +: REG_WIDTH] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CFG; k++) m_regs[k] = '0;
    m_prio = 1'b0; m_arv = 1'b0; m_brv = 1'b0; m_err = 1'b0;
    m_ard = '0; m_brd = '0;
  endtask

  // One clock: check readies before the edge, advance model, check outputs after.
  task automatic step();
    bit ea, eb, g_we;
    int g_addr;
    logic [REG_WIDTH-1:0] g_wd;
    #1;
    ea = !rst && ena && a_valid && (!b_valid || m_prio == 1'b0);
    eb = !rst && ena && b_valid && (!a_valid || m_prio == 1'b1);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    g_we   = ea ? a_we : b_we;
    g_addr = ea ? int'(a_addr) : int'(b_addr);
    g_wd   = ea ? a_wdata : b_wdata;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_arv = 1'b0; m_brv = 1'b0;
      m_err = (ea || eb) && (g_addr >= NUM_CFG);
      if (ea || eb) begin
        if (!g_we) begin
          if (ea) begin m_arv = 1'b1; m_ard = (g_addr < NUM_CFG) ? m_regs[g_addr] : '0; end
          else    begin m_brv = 1'b1; m_brd = (g_addr < NUM_CFG) ? m_regs[g_addr] : '0; end
        end else if (g_addr < NUM_CFG) begin
          m_regs[g_addr] = g_wd;
        end
        m_prio = ea;
      end
    end
    check("config_regs", config_regs, model_flat());
    check("a_rvalid", a_rvalid, m_arv);
    check("a_rdata", a_rdata, m_ard);
    check("b_rvalid", b_rvalid, m_brv);
    check("b_rdata", b_rdata, m_brd);
    check("addr_err", addr_err, m_err);
    last_a_acc = ea;
    last_b_acc = eb;
  endtask

  task automatic set_a(input bit v, input bit we, input int addr, input int wd);
    a_valid = v; a_we = we; a_addr = addr[ADDR_WIDTH-1:0]; a_wdata = wd[REG_WIDTH-1:0];
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input int wd);
    b_valid = v; b_we = we; b_addr = addr[ADDR_WIDTH-1:0]; b_wdata = wd[REG_WIDTH-1:0];
  endtask

  initial begin
    logic [REG_WIDTH-1:0] exp_byte;
    rst = 1'b1; ena = 1'b1;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    model_reset();
    step(); step();
    rst = 1'b0;
    step();
    check("reset_cfg_zero", config_regs, '0);

    // First contended grant goes to A, then B.
    set_a(1, 0, 0, 0); set_b(1, 0, 0, 0);
    step();
    check("first_contend_A", last_a_acc, 1'b1);
    set_a(0, 0, 0, 0);
    step();
    check("second_contend_B", last_b_acc, 1'b1);
    set_b(0, 0, 0, 0);

    // A writes 0xCA to addr 0, B reads it back.
    set_a(1, 1, 0, 8'hCA);
    step();
    check("write_visible", config_regs[7:0], 8'hCA);
    set_a(0, 0, 0, 0); set_b(1, 0, 0, 0);
    step();
    check("b_read_rvalid", b_rvalid, 1'b1);
    check("b_read_data", b_rdata, 8'hCA);
    set_b(0, 0, 0, 0);
    step();

    // Continuous contention: grants alternate A,B,A,B,A,B.
    set_a(1, 1, 5, 8'hA0); set_b(1, 1, 10, 8'hB0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("alt_grant_a", last_a_acc, (i % 2) == 0);
      check("alt_grant_b", last_b_acc, (i % 2) == 1);
      if (last_a_acc) set_a(1, 1, 6 + i, 8'hA1 + i);
      if (last_b_acc) set_b(1, 1, 11 + i, 8'hB1 + i);
    end
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);

    // Preload 1..4, then B streams four reads back to back.
    for (int i = 1; i <= 4; i++) begin
      set_a(1, 1, i, 8'h11 * i);
      step();
    end
    set_a(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      set_b(1, 0, i, 0);
      step();
      exp_byte = 8'h11 * i;
      check("stream_ready", last_b_acc, 1'b1);
      check("stream_rvalid", b_rvalid, 1'b1);
      check("stream_rdata", b_rdata, exp_byte);
    end
    set_b(0, 0, 0, 0);
    step();

    // Out-of-range write and read.
    set_a(1, 1, 20, 8'hFF);
    step();
    check("oor_wr_err", addr_err, 1'b1);
    set_a(0, 0, 0, 0);
    step();
    check("oor_err_clears", addr_err, 1'b0);
    set_a(1, 0, 20, 0);
    step();
    check("oor_rd_err", addr_err, 1'b1);
    check("oor_rd_rvalid", a_rvalid, 1'b1);
    check("oor_rd_zero", a_rdata, 8'h00);
    set_a(0, 0, 0, 0);
    step();

    // Reset right after an accepted B read; then ena low.
    set_b(1, 0, 1, 0);
    step();
    set_b(0, 0, 0, 0); rst = 1'b1;
    step();
    check("rst_no_rvalid", b_rvalid, 1'b0);
    check("rst_cfg_zero", config_regs, '0);
    rst = 1'b0;
    set_a(1, 0, 2, 0); set_b(1, 0, 3, 0);
    step();
    check("post_rst_prio_A", last_a_acc, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ena_low_no_ready", {last_a_acc, last_b_acc}, 2'b00);
    end
    ena = 1'b1;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    step();

    // Random traffic obeying the hold-until-ready rule.
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || last_a_acc)
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19), $urandom_range(0, 255));
      if (!b_valid || last_b_acc)
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19), $urandom_range(0, 255));
      ena = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
